// File: rtl/mux_4to1_rr_if.sv
// Stream bundle for the 4-to-1 round-robin packet mux: four source channels
// merged onto one output channel tagged with its source index.
interface mux_4to1_rr_if #(
  parameter int DATA_W = 8
);
  logic [3:0]          in_valid;
  logic [3:0]          in_ready;
  logic [3:0]          in_last;
  logic [4*DATA_W-1:0] in_data;
  logic                out_valid;
  logic                out_ready;
  logic                out_last;
  logic [1:0]          out_sel;
  logic [DATA_W-1:0]   out_data;

  // Traffic side: drives the source channels and the downstream accept.
  modport master (
    output in_valid, in_last, in_data, out_ready,
    input  in_ready, out_valid, out_last, out_sel, out_data
  );

  // Mux side: accepts source beats and presents the merged stream.
  modport slave (
    input  in_valid, in_last, in_data, out_ready,
    output in_ready, out_valid, out_last, out_sel, out_data
  );
endinterface

// File: rtl/mux_4to1_rr.sv
// 4-to-1 streaming packet multiplexer with packet-granular round-robin
// arbitration. A one-cycle IDLE state picks the next channel; BUSY forwards
// that channel's beats into a single output register until its last beat.
// out_sel carries the source index so a downstream demux can route it back.
module mux_4to1_rr #(
  parameter int DATA_W = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  mux_4to1_rr_if.slave    bus
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [1:0]          r_rr_ptr;
  logic [1:0]          w_rr_ptr_nxt;
  logic [1:0]          r_grant;
  logic [1:0]          w_grant_nxt;
  logic [1:0]          w_pick;
  logic [3:0]          w_in_ready;

  logic                w_gnt_vld;
  logic                w_gnt_last;
  logic [DATA_W-1:0]   w_gnt_data;
  logic                w_load_ok;
  logic                w_in_xfer;

  logic                r_out_vld_p1;
  logic                r_out_last_p1;
  logic [1:0]          r_out_sel_p1;
  logic [DATA_W-1:0]   r_out_data_p1;

  // First requesting channel scanning ptr, ptr+1, ... modulo 4.
  function automatic logic [1:0] rr_pick(input logic [3:0] req, input logic [1:0] ptr);
    logic [1:0] idx;
    logic [1:0] pick;
    logic       found;
    pick  = ptr;
    found = 1'b0;
    for (int k = 0; k < 4; k++) begin
      idx = ptr + 2'(k);
      if (!found && req[idx]) begin
        pick  = idx;
        found = 1'b0 | 1'b1;
      end
    end
    return pick;
  endfunction

  assign w_pick     = rr_pick(bus.in_valid, r_rr_ptr);

  // Granted channel's beat, selected out of the flat data bus.
  assign w_gnt_vld  = bus.in_valid[r_grant];
  assign w_gnt_last = bus.in_last[r_grant];
  assign w_gnt_data = bus.in_data[r_grant*DATA_W +: DATA_W];

  // The output register can take a new beat when empty or draining this cycle.
  assign w_load_ok  = ~r_out_vld_p1 | bus.out_ready;
  assign w_in_xfer  = (r_state == BUSY) & w_gnt_vld & w_load_ok;

  // State, grant and round-robin pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_grant  <= 2'd0;
      r_rr_ptr <= 2'd0;
    end else begin
      r_state  <= w_state_nxt;
      r_grant  <= w_grant_nxt;
      r_rr_ptr <= w_rr_ptr_nxt;
    end
  end

  // Next-state logic: arbitrate in IDLE, hold the grant for a whole packet in BUSY.
  always_comb begin
    w_state_nxt  = r_state;
    w_grant_nxt  = r_grant;
    w_rr_ptr_nxt = r_rr_ptr;
    w_in_ready   = 4'b0000;
    case (r_state)
      IDLE: begin
        if (|bus.in_valid) begin
          w_grant_nxt = w_pick;
          w_state_nxt = BUSY;
        end
      end
      BUSY: begin
        w_in_ready[r_grant] = w_load_ok;
        // Pointer only moves once the packet is complete, so a stalled
        // packet never lets another channel jump the queue.
        if (w_in_xfer && w_gnt_last) begin
          w_state_nxt  = IDLE;
          w_rr_ptr_nxt = r_grant + 2'd1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign bus.in_ready = w_in_ready;

  // ---- stage p1: output beat register ----
  // Loads on every input transfer; a drain with no new load empties it, and a
  // simultaneous drain and load keeps it full for one beat per cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_vld_p1  <= 1'b0;
      r_out_last_p1 <= 1'b0;
      r_out_sel_p1  <= 2'd0;
      r_out_data_p1 <= '0;
    end else if (w_in_xfer) begin
      r_out_vld_p1  <= 1'b1;
      r_out_last_p1 <= w_gnt_last;
      r_out_sel_p1  <= r_grant;
      r_out_data_p1 <= w_gnt_data;
    end else if (bus.out_ready) begin
      r_out_vld_p1  <= 1'b0;
    end
  end

  assign bus.out_valid = r_out_vld_p1;
  assign bus.out_last  = r_out_last_p1;
  assign bus.out_sel   = r_out_sel_p1;
  assign bus.out_data  = r_out_data_p1;

endmodule

// File: tb/tb_mux_4to1_rr.sv
// Testbench for mux_4to1_rr: per-channel source drivers feed directed packets,
// expected output beats are queued by hand, and a monitor pops and compares
// each beat the DUT hands downstream.
module tb_mux_4to1_rr;
  localparam int DATA_W = 8;
  localparam int QD     = 16;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
    logic [3:0] dly;
  } beat_t;

  typedef struct packed {
    logic [1:0] sel;
    logic [7:0] data;
    logic       last;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mux_4to1_rr_if #(.DATA_W(DATA_W)) bus();

  mux_4to1_rr #(.DATA_W(DATA_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  beat_t src_mem [4][QD];
  int    src_head [4];
  int    src_tail [4];
  int    src_wait [4];
  int    vld_rise [4];
  exp_t  exp_q[$];
  int    pop_cyc[$];
  int    cyc    = 0;
  int    checks = 0;
  int    errors = 0;
  logic [3:0] acc;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  task automatic push_src(input int ch, input logic [7:0] data, input logic last, input logic [3:0] dly);
    beat_t b;
    b.data = data;
    b.last = last;
    b.dly  = dly;
    src_mem[ch][src_tail[ch]] = b;
    src_tail[ch]++;
  endtask

  task automatic push_exp(input logic [1:0] sel, input logic [7:0] data, input logic last);
    exp_t e;
    e.sel  = sel;
    e.data = data;
    e.last = last;
    exp_q.push_back(e);
  endtask

  task automatic src_rewind();
    for (int i = 0; i < 4; i++) begin
      src_head[i] = 0;
      src_tail[i] = 0;
      src_wait[i] = -1;
    end
  endtask

  task automatic flush();
    src_rewind();
    exp_q.delete();
    pop_cyc.delete();
  endtask

  function automatic int pc(input int i);
    if (i < pop_cyc.size()) return pop_cyc[i];
    return -1000;
  endfunction

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    check({name, "_drain"}, 32'(exp_q.size()), 32'd0);
    repeat (2) @(posedge clk);
  endtask

  task automatic reset_dut();
    @(posedge clk); #3;
    rst_n = 1'b0;
    flush();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic wait_pops(input int cnt);
    int n;
    n = 0;
    while (pop_cyc.size() < cnt && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("wait_pops", 32'(pop_cyc.size() >= cnt), 32'd1);
  endtask

  // Source drivers: advance on an accepted beat, honour per-beat idle delay.
  initial begin
    bus.in_valid = '0;
    bus.in_last  = '0;
    bus.in_data  = '0;
    for (int i = 0; i < 4; i++) begin
      src_head[i] = 0;
      src_tail[i] = 0;
      src_wait[i] = -1;
      vld_rise[i] = 0;
    end
    forever begin
      @(posedge clk); #1;
      for (int i = 0; i < 4; i++) begin
        if (acc[i] && src_head[i] != src_tail[i]) begin
          src_head[i]++;
          src_wait[i] = -1;
        end
        if (src_head[i] != src_tail[i]) begin
          if (src_wait[i] < 0) src_wait[i] = int'(src_mem[i][src_head[i]].dly);
          if (src_wait[i] > 0) begin
            src_wait[i]--;
            bus.in_valid[i] = 1'b0;
          end else begin
            if (!bus.in_valid[i]) vld_rise[i] = cyc;
            bus.in_valid[i]         = 1'b1;
            bus.in_last[i]          = src_mem[i][src_head[i]].last;
            bus.in_data[i*8 +: 8]   = src_mem[i][src_head[i]].data;
          end
        end else begin
          bus.in_valid[i] = 1'b0;
        end
      end
    end
  end

  // Monitor: record source accepts and score each downstream beat.
  initial begin
    exp_t e;
    acc = '0;
    forever begin
      @(negedge clk);
      acc = bus.in_valid & bus.in_ready;
      if (rst_n && bus.out_valid && bus.out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_beat: got sel=%0d data=%h last=%0d with nothing expected",
                   bus.out_sel, bus.out_data, bus.out_last);
        end else begin
          e = exp_q.pop_front();
          pop_cyc.push_back(cyc);
          if ({bus.out_sel, bus.out_data, bus.out_last} !== e) begin
            errors++;
            $display("FAIL beat: got sel=%0d data=%h last=%0d expected sel=%0d data=%h last=%0d",
                     bus.out_sel, bus.out_data, bus.out_last, e.sel, e.data, e.last);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bus.out_ready = 1'b1;
    rst_n         = 1'b0;
    repeat (2) @(posedge clk); #2;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_in_ready",  32'(bus.in_ready),  32'd0);
    check("rst_out_sel",   32'(bus.out_sel),   32'd0);
    check("rst_out_last",  32'(bus.out_last),  32'd0);
    check("rst_out_data",  32'(bus.out_data),  32'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Test 1: asynchronous reset in the middle of a ch2 packet.
    @(posedge clk); #3;
    for (int k = 0; k < 4; k++) push_src(2, 8'h51 + 8'(k), k == 3, 4'd0);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!bus.out_valid && n < 20);
    check("t1_pre_valid", 32'(bus.out_valid), 32'd1);
    check("t1_pre_sel",   32'(bus.out_sel),   32'd2);
    #2 rst_n = 1'b0;
    #1;
    check("t1_async_valid", 32'(bus.out_valid), 32'd0);
    check("t1_async_ready", 32'(bus.in_ready),  32'd0);
    check("t1_async_sel",   32'(bus.out_sel),   32'd0);
    flush();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Test 2: ch2 three-beat packet, full throughput, 2-cycle latency.
    @(posedge clk); #3;
    src_rewind();
    pop_cyc.delete();
    push_src(2, 8'hA1, 1'b0, 4'd0);
    push_src(2, 8'hA2, 1'b0, 4'd0);
    push_src(2, 8'hA3, 1'b1, 4'd0);
    push_exp(2'd2, 8'hA1, 1'b0);
    push_exp(2'd2, 8'hA2, 1'b0);
    push_exp(2'd2, 8'hA3, 1'b1);
    wait_drain("t2");
    check("t2_latency", 32'(pc(0) - vld_rise[2]), 32'd2);
    check("t2_span",    32'(pc(2) - pc(0)),       32'd2);

    // Test 3: all four channels with back-to-back single-beat packets.
    reset_dut();
    @(posedge clk); #3;
    for (int j = 0; j < 2; j++)
      for (int i = 0; i < 4; i++) begin
        push_src(i, 8'(i*16 + j), 1'b1, 4'd0);
        push_exp(2'(i), 8'(i*16 + j), 1'b1);
      end
    wait_drain("t3");

    // Test 4: ch1 four beats with downstream stalled for 5 cycles.
    @(posedge clk); #3;
    src_rewind();
    pop_cyc.delete();
    push_src(1, 8'hB1, 1'b0, 4'd0);
    push_src(1, 8'hB2, 1'b0, 4'd0);
    push_src(1, 8'hB3, 1'b0, 4'd0);
    push_src(1, 8'hB4, 1'b1, 4'd0);
    push_exp(2'd1, 8'hB1, 1'b0);
    push_exp(2'd1, 8'hB2, 1'b0);
    push_exp(2'd1, 8'hB3, 1'b0);
    push_exp(2'd1, 8'hB4, 1'b1);
    wait_pops(1);
    bus.out_ready = 1'b0;
    for (int s = 0; s < 5; s++) begin
      #1;
      check("t4_bp_in_ready", 32'(bus.in_ready),  32'd0);
      check("t4_bp_hold",     32'(bus.out_data),  32'hB2);
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    wait_drain("t4");

    // Test 5: ch0 packet is atomic against a ch3 request arriving mid-packet.
    @(posedge clk); #3;
    src_rewind();
    pop_cyc.delete();
    for (int k = 0; k < 4; k++) begin
      push_src(0, 8'hC0 + 8'(k), k == 3, 4'd0);
      push_exp(2'd0, 8'hC0 + 8'(k), k == 3);
    end
    push_src(3, 8'hD0, 1'b0, 4'd2);
    push_src(3, 8'hD1, 1'b1, 4'd0);
    push_exp(2'd3, 8'hD0, 1'b0);
    push_exp(2'd3, 8'hD1, 1'b1);
    wait_drain("t5");

    // Test 6: pointer wraps after ch3 to pick ch0; gap inside the ch0 packet.
    @(posedge clk); #3;
    src_rewind();
    pop_cyc.delete();
    push_src(3, 8'hE0, 1'b1, 4'd0);
    push_src(3, 8'hE1, 1'b1, 4'd0);
    push_src(0, 8'hF0, 1'b0, 4'd2);
    push_src(0, 8'hF1, 1'b0, 4'd3);
    push_src(0, 8'hF2, 1'b1, 4'd0);
    push_exp(2'd3, 8'hE0, 1'b1);
    push_exp(2'd0, 8'hF0, 1'b0);
    push_exp(2'd0, 8'hF1, 1'b0);
    push_exp(2'd0, 8'hF2, 1'b1);
    push_exp(2'd3, 8'hE1, 1'b1);
    wait_pops(2);
    check("t6_gap_grant_held", 32'(bus.in_ready),  32'h1);
    check("t6_gap_out_empty",  32'(bus.out_valid), 32'd0);
    wait_drain("t6");
    check("t6_gap_len", 32'(pc(2) - pc(1)), 32'd4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
